// File: rtl/dat_init_seq.sv
// DAT RAM initialisation sequencer: walks every DAT entry writing identity or fill mappings.
// Optional high-byte support (REG_BASE+2 register, _we_dat_h strobe) is enabled by DAT_INIT_HIGH_EN.
module dat_init_seq #(
  parameter int          ADDR_W     = 15,
  parameter int          AUTO_START = 1,
  parameter logic [15:0] REG_BASE   = 16'hfd06
) (
  input  logic              e,
  input  logic              _reset,
  input  logic [15:0]       address_cpu,
  input  logic [7:0]        data_cpu_in,
  input  logic              r_w_cpu,
  output logic [ADDR_W-1:0] address_dat,
  output logic [15:0]       data_dat_out,
  output logic              _we_dat_l,
  output logic              _we_dat_h,
  output logic              dat_own,
  output logic              busy,
  output logic [7:0]        data_out,
  output logic              rd_sel
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic              mode_q, mode_d;
  logic              done_q, done_d;
  logic              auto_q;
  logic [7:0]        fill_q;
  logic [7:0]        fill_lat_q, fill_lat_d;
  logic              own_q, own_d;
  logic              we_l_q, we_l_d;
  logic              we_h_q, we_h_d;
  logic [7:0]        hfill_q;
  logic [7:0]        hfill_lat_q, hfill_lat_d;

  logic hit_ctl, hit_fill, hit_hi;
  logic wr_ctl, wr_fill, wr_hi;
  logic start_req, abort_req;
  logic [7:0] idx8, data_lo, data_hi;

  assign hit_ctl  = (address_cpu == REG_BASE);
  assign hit_fill = (address_cpu == REG_BASE + 16'd1);
`ifdef DAT_INIT_HIGH_EN
  assign hit_hi   = (address_cpu == REG_BASE + 16'd2);
`else
  assign hit_hi   = 1'b0;
`endif

  assign wr_ctl  = hit_ctl  & ~r_w_cpu;
  assign wr_fill = hit_fill & ~r_w_cpu;
  assign wr_hi   = hit_hi   & ~r_w_cpu;

  // Abort has priority over a start written in the same cycle.
  assign abort_req = wr_ctl & data_cpu_in[2];
  assign start_req = auto_q | (wr_ctl & data_cpu_in[0] & ~data_cpu_in[2]);

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    mode_d      = mode_q;
    done_d      = done_q;
    fill_lat_d  = fill_lat_q;
    hfill_lat_d = hfill_lat_q;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          mode_d      = auto_q ? 1'b0 : data_cpu_in[1];
          fill_lat_d  = fill_q;
          hfill_lat_d = hfill_q;
          index_d     = '0;
          done_d      = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: state_d = abort_req ? IDLE : WRITE;
      WRITE: begin
        // Terminal entry is detected before incrementing, so index never wraps.
        if (abort_req) begin
          state_d = IDLE;
        end else if (index_q == {ADDR_W{1'b1}}) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = SETUP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-ownership and strobes are registered from next state so they never glitch.
  always_comb begin
    own_d  = (state_d == SETUP) || (state_d == WRITE);
    we_l_d = (state_d != WRITE);
`ifdef DAT_INIT_HIGH_EN
    we_h_d = (state_d != WRITE);
`else
    we_h_d = 1'b1;
`endif
  end

  always_ff @(posedge e or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      auto_q      <= (AUTO_START != 0);
      fill_q      <= 8'h00;
      fill_lat_q  <= 8'h00;
      hfill_q     <= 8'h00;
      hfill_lat_q <= 8'h00;
      own_q       <= 1'b0;
      we_l_q      <= 1'b1;
      we_h_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      mode_q      <= mode_d;
      done_q      <= done_d;
      auto_q      <= 1'b0;
      fill_lat_q  <= fill_lat_d;
      hfill_lat_q <= hfill_lat_d;
      own_q       <= own_d;
      we_l_q      <= we_l_d;
      we_h_q      <= we_h_d;
      if (wr_fill) fill_q  <= data_cpu_in;
      if (wr_hi)   hfill_q <= data_cpu_in;
    end
  end

  assign idx8    = 8'(index_q);
  assign data_lo = mode_q ? fill_lat_q : {5'b0, idx8[2:0]};
`ifdef DAT_INIT_HIGH_EN
  assign data_hi = mode_q ? hfill_lat_q : 8'h00;
`else
  assign data_hi = 8'h00;
`endif

  assign dat_own      = own_q;
  assign busy         = own_q;
  assign address_dat  = own_q ? index_q : '0;
  assign data_dat_out = own_q ? {data_hi, data_lo} : 16'h0000;
  assign _we_dat_l    = we_l_q;
  assign _we_dat_h    = we_h_q;

  assign rd_sel = r_w_cpu & (hit_ctl | hit_fill | hit_hi);

  always_comb begin
    data_out = 8'h00;
    if (hit_ctl)       data_out = {own_q, done_q, 5'b0, mode_q};
    else if (hit_fill) data_out = fill_q;
    else if (hit_hi)   data_out = hfill_q;
  end

endmodule

// File: tb/tb_dat_init_seq.sv
// Directed self-checking bench for dat_init_seq with a small DAT RAM model (ADDR_W=4, AUTO_START=1).
module tb_dat_init_seq;

  localparam int          AW = 4;
  localparam logic [15:0] RB = 16'hfd06;
`ifdef DAT_INIT_HIGH_EN
  localparam logic [7:0]  EXP_HI  = 8'h3c;
  localparam logic        EXP_WEH = 1'b0;
`else
  localparam logic [7:0]  EXP_HI  = 8'h00;
  localparam logic        EXP_WEH = 1'b1;
`endif

  logic          e;
  logic          _reset;
  logic [15:0]   address_cpu;
  logic [7:0]    data_cpu_in;
  logic          r_w_cpu;
  logic [AW-1:0] address_dat;
  logic [15:0]   data_dat_out;
  logic          _we_dat_l, _we_dat_h, dat_own, busy, rd_sel;
  logic [7:0]    data_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [16];
  int          exp_idx, wr_cnt, seq_err;

  dat_init_seq #(.ADDR_W(AW), .AUTO_START(1), .REG_BASE(RB)) dut (
    .e(e), ._reset(_reset), .address_cpu(address_cpu), .data_cpu_in(data_cpu_in),
    .r_w_cpu(r_w_cpu), .address_dat(address_dat), .data_dat_out(data_dat_out),
    ._we_dat_l(_we_dat_l), ._we_dat_h(_we_dat_h), .dat_own(dat_own), .busy(busy),
    .data_out(data_out), .rd_sel(rd_sel)
  );

  initial begin
    e = 1'b0;
    forever #5 e = ~e;
  end

  // DAT RAM model: writes land on the edge that ends a low-strobe cycle.
  always @(posedge e) begin
    if (_reset && !_we_dat_l) begin
      mem[address_dat] = data_dat_out;
      if (int'(address_dat) != exp_idx) seq_err++;
      exp_idx++;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge e);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
    address_cpu = a;
    data_cpu_in = d;
    r_w_cpu     = 1'b0;
    tick();
    r_w_cpu     = 1'b1;
    address_cpu = 16'h0000;
  endtask

  task automatic check_read(input string tag, input logic [15:0] a, input logic [7:0] expv);
    address_cpu = a;
    r_w_cpu     = 1'b1;
    #1;
    check({tag, "_sel"}, 32'(rd_sel), 32'd1);
    check(tag, 32'(data_out), 32'(expv));
    address_cpu = 16'h0000;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mem[i] = 16'hffff;
    exp_idx = 0;
    wr_cnt  = 0;
    seq_err = 0;
  endtask

  initial begin
    _reset      = 1'b0;
    address_cpu = 16'h0000;
    data_cpu_in = 8'h00;
    r_w_cpu     = 1'b1;
    clear_model();
    ticks(3);

    check("rst_own",  32'(dat_own),      32'd0);
    check("rst_busy", 32'(busy),         32'd0);
    check("rst_wel",  32'(_we_dat_l),    32'd1);
    check("rst_weh",  32'(_we_dat_h),    32'd1);
    check("rst_addr", 32'(address_dat),  32'd0);
    check("rst_data", 32'(data_dat_out), 32'd0);
    check_read("rst_status", RB, 8'h00);

    // Auto-start identity clear on release.
    _reset = 1'b1;
    tick();
    check("auto_own",   32'(dat_own),     32'd1);
    check("auto_busy",  32'(busy),        32'd1);
    check("auto_addr0", 32'(address_dat), 32'd0);
    check("auto_setup_wel", 32'(_we_dat_l), 32'd1);
    tick();
    check("auto_write_wel", 32'(_we_dat_l), 32'd0);
    check("auto_write_addr", 32'(address_dat), 32'd0);
    ticks(31);
    check("auto_done_own",  32'(dat_own), 32'd0);
    check("auto_done_busy", 32'(busy),    32'd0);
    check_read("auto_done_status", RB, 8'h40);
    for (int i = 0; i < 16; i++) check($sformatf("id_mem%0d", i), 32'(mem[i]), 32'(i % 8));
    check("auto_wr_cnt", 32'(wr_cnt),  32'd16);
    check("auto_seq",    32'(seq_err), 32'd0);
    tick();
    check_read("auto_idle_status", RB, 8'h40);

    // Fill mode.
    clear_model();
    write_reg(RB + 16'd1, 8'ha5);
    check_read("fill_reg", RB + 16'd1, 8'ha5);
`ifdef DAT_INIT_HIGH_EN
    write_reg(RB + 16'd2, 8'h3c);
    check_read("hfill_reg", RB + 16'd2, 8'h3c);
`endif
    write_reg(RB, 8'h03);
    check("fill_own", 32'(dat_own), 32'd1);
    check_read("fill_run_status", RB, 8'h81);
    check("fill_setup_data", 32'(data_dat_out), 32'({EXP_HI, 8'ha5}));
    tick();
    check("fill_wel", 32'(_we_dat_l), 32'd0);
    check("fill_weh", 32'(_we_dat_h), 32'(EXP_WEH));
    check("fill_write_data", 32'(data_dat_out), 32'({EXP_HI, 8'ha5}));
    ticks(31);
    check("fill_done_busy", 32'(busy), 32'd0);
    check_read("fill_done_status", RB, 8'h41);
    for (int i = 0; i < 16; i++) check($sformatf("fill_mem%0d", i), 32'(mem[i]), 32'({EXP_HI, 8'ha5}));
    tick();

    // Start while busy is ignored.
    clear_model();
    write_reg(RB, 8'h01);
    ticks(5);
    write_reg(RB, 8'h01);
    check("rs_still_busy", 32'(busy), 32'd1);
    ticks(26);
    check("rs_done_busy", 32'(busy), 32'd0);
    check_read("rs_done_status", RB, 8'h40);
    check("rs_wr_cnt", 32'(wr_cnt),  32'd16);
    check("rs_seq",    32'(seq_err), 32'd0);
    tick();

    // Start together with abort in IDLE does nothing.
    write_reg(RB, 8'h05);
    check("sa_idle_own", 32'(dat_own), 32'd0);

    // Abort at entry 5.
    clear_model();
    write_reg(RB, 8'h01);
    ticks(10);
    check("ab_addr5", 32'(address_dat), 32'd5);
    check("ab_own_before", 32'(dat_own), 32'd1);
    write_reg(RB, 8'h04);
    check("ab_own",  32'(dat_own),   32'd0);
    check("ab_busy", 32'(busy),      32'd0);
    check("ab_wel",  32'(_we_dat_l), 32'd1);
    check_read("ab_status", RB, 8'h00);
    check("ab_wr_cnt", 32'(wr_cnt), 32'd5);
    for (int i = 0; i < 16; i++)
      check($sformatf("ab_mem%0d", i), 32'(mem[i]), (i < 5) ? 32'(i) : 32'h0000ffff);
    tick();
    check("ab_stay_idle", 32'(dat_own), 32'd0);

    // Asynchronous reset in the middle of a WRITE cycle.
    write_reg(RB, 8'h01);
    tick();
    check("mr_wel_low", 32'(_we_dat_l), 32'd0);
    _reset = 1'b0;
    #1;
    check("mr_wel",  32'(_we_dat_l),   32'd1);
    check("mr_weh",  32'(_we_dat_h),   32'd1);
    check("mr_own",  32'(dat_own),     32'd0);
    check("mr_addr", 32'(address_dat), 32'd0);
    check_read("mr_status", RB, 8'h00);
    check_read("mr_fill", RB + 16'd1, 8'h00);
    address_cpu = RB + 16'd2;
    #1;
`ifdef DAT_INIT_HIGH_EN
    check("hi_rd_sel", 32'(rd_sel), 32'd1);
`else
    check("hi_rd_sel", 32'(rd_sel), 32'd0);
`endif
    address_cpu = RB;
    r_w_cpu     = 1'b0;
    #1;
    check("wr_rd_sel", 32'(rd_sel), 32'd0);
    r_w_cpu     = 1'b1;
    address_cpu = 16'h0000;
    tick();
    check("mr_held_own", 32'(dat_own), 32'd0);
    _reset = 1'b1;
    tick();
    check("mr_autostart_own", 32'(dat_own), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
